// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing one period counter. Each channel holds a
// double-buffered config that swaps into the active set at the period wrap.

module pwm_chan #(
    parameter int WIDTH     = 6,
    parameter int DIV_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 wrap_i,
    input  logic [WIDTH-1:0]     cnt_i,
    input  logic                 wr_i,
    input  logic [1:0]           mode_i,
    input  logic [WIDTH-1:0]     duty_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 pend_o,
    output logic                 pwm_o
);
    localparam logic [1:0]       M_OFF     = 2'b00;
    localparam logic [1:0]       M_STATIC  = 2'b01;
    localparam logic [1:0]       M_BREATHE = 2'b10;
    localparam logic [1:0]       M_FULL    = 2'b11;
    localparam logic [WIDTH-1:0] LVL_MAX   = '1;
    localparam logic [WIDTH-1:0] LVL_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] LVL_TOP   = LVL_MAX - LVL_ONE;

    logic [1:0]           mode_q, sh_mode_q;
    logic [WIDTH-1:0]     duty_q, sh_duty_q;
    logic [DIV_WIDTH-1:0] div_q, sh_div_q;
    logic                 pend_q;
    logic [WIDTH-1:0]     ramp_q, ramp_d;
    logic                 up_q, up_d;
    logic [DIV_WIDTH-1:0] tick_q, tick_d;
    logic [WIDTH-1:0]     level;
    logic                 pwm_q, pwm_d;
    logic                 enter_breathe;

    // Only a transition into breathe restarts the ramp; breathe->breathe keeps phase.
    assign enter_breathe = pend_q && (sh_mode_q == M_BREATHE) && (mode_q != M_BREATHE);

    always_comb begin
        ramp_d = ramp_q;
        up_d   = up_q;
        tick_d = tick_q;
        if (wrap_i) begin
            if (enter_breathe) begin
                ramp_d = LVL_ONE;
                up_d   = 1'b1;
                tick_d = '0;
            end else if (mode_q == M_BREATHE) begin
                if (tick_q == div_q) begin
                    tick_d = '0;
                    if (up_q) begin
                        ramp_d = ramp_q + LVL_ONE;
                        if (ramp_d == LVL_TOP) up_d = 1'b0;
                    end else begin
                        ramp_d = ramp_q - LVL_ONE;
                        if (ramp_d == LVL_ONE) up_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + DIV_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        case (mode_q)
            M_STATIC:  level = duty_q;
            M_BREATHE: level = ramp_q;
            M_FULL:    level = LVL_MAX;
            default:   level = '0;
        endcase
        // Max level is held high across the whole period, including counter == max.
        pwm_d = en_i && (mode_q != M_OFF) && ((level > cnt_i) || (level == LVL_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= M_OFF;
            duty_q    <= '0;
            div_q     <= '0;
            sh_mode_q <= M_OFF;
            sh_duty_q <= '0;
            sh_div_q  <= '0;
            pend_q    <= 1'b0;
            ramp_q    <= LVL_ONE;
            up_q      <= 1'b1;
            tick_q    <= '0;
            pwm_q     <= 1'b0;
        end else begin
            if (wrap_i && pend_q) begin
                mode_q <= sh_mode_q;
                duty_q <= sh_duty_q;
                div_q  <= sh_div_q;
                pend_q <= 1'b0;
            end
            // wr_i is only raised while pend_q is clear, so it never races the load.
            if (wr_i) begin
                sh_mode_q <= mode_i;
                sh_duty_q <= duty_i;
                sh_div_q  <= div_i;
                pend_q    <= 1'b1;
            end
            ramp_q <= ramp_d;
            up_q   <= up_d;
            tick_q <= tick_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pend_o = pend_q;
    assign pwm_o  = pwm_q;
endmodule

module pwm_bank #(
    parameter int WIDTH     = 6,
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 10
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            en,
    input  logic                                            cfg_valid,
    output logic                                            cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
    input  logic [1:0]                                      cfg_mode,
    input  logic [WIDTH-1:0]                                cfg_duty,
    input  logic [DIV_WIDTH-1:0]                            cfg_step_div,
    output logic [CHANNELS-1:0]                             pwm_out,
    output logic                                            period_start
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]    cnt_q;
    logic                ps_q;
    logic                wrap;
    logic                accept;
    logic [CHANNELS-1:0] wr;
    logic [CHANNELS-1:0] pend;
    logic [(2**CW)-1:0]  pend_ext;

    assign wrap = en && (cnt_q == '1);

    // Unpopulated channel slots read as not-pending, so writes to them are taken and dropped.
    always_comb begin
        pend_ext                 = '0;
        pend_ext[CHANNELS-1:0]   = pend;
    end

    assign cfg_ready = !pend_ext[cfg_chan];
    assign accept    = cfg_valid && cfg_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign wr[i] = accept && (cfg_chan == CW'(i));

        pwm_chan #(
            .WIDTH     (WIDTH),
            .DIV_WIDTH (DIV_WIDTH)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en_i   (en),
            .wrap_i (wrap),
            .cnt_i  (cnt_q),
            .wr_i   (wr[i]),
            .mode_i (cfg_mode),
            .duty_i (cfg_duty),
            .div_i  (cfg_step_div),
            .pend_o (pend[i]),
            .pwm_o  (pwm_out[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ps_q  <= 1'b0;
        end else begin
            if (en) cnt_q <= cnt_q + WIDTH'(1);
            ps_q <= en && (cnt_q == '0);
        end
    end

    assign period_start = ps_q;
endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank (WIDTH=6, CHANNELS=4): directed period-level scenarios
// plus randomized traffic against a period-level reference model.

module tb_pwm_bank;
    localparam int CH = 4;

    logic       clk = 1'b0;
    logic       rst, en, cfg_valid, cfg_ready, period_start;
    logic [1:0] cfg_chan, cfg_mode;
    logic [5:0] cfg_duty;
    logic [9:0] cfg_step_div;
    logic [3:0] pwm_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pwm_bank #(.WIDTH(6), .CHANNELS(CH), .DIV_WIDTH(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_chan     (cfg_chan),
        .cfg_mode     (cfg_mode),
        .cfg_duty     (cfg_duty),
        .cfg_step_div (cfg_step_div),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    // Reference model: breathe level is a closed-form function of how many
    // periods the channel has spent in breathe mode since entering it.
    int   m_cnt;
    int   m_mode[CH], m_duty[CH], m_div[CH], m_bc[CH];
    int   s_mode[CH], s_duty[CH], s_div[CH];
    bit   m_pend[CH];
    logic [3:0] e_pwm;
    logic e_ps;

    int   hi[CH];
    logic [63:0] b0;

    function automatic int ramp_at(input int k);
        int m;
        m = k % 122;
        return (m <= 61) ? (m + 1) : (123 - m);
    endfunction

    function automatic int m_level(input int c);
        case (m_mode[c])
            1:       return m_duty[c];
            2:       return ramp_at(m_bc[c] / (m_div[c] + 1));
            3:       return 63;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        bit acc;
        int lv;
        if (rst) begin
            m_cnt = 0;
            for (int c = 0; c < CH; c++) begin
                m_mode[c] = 0; m_duty[c] = 0; m_div[c] = 0; m_bc[c] = 0;
                s_mode[c] = 0; s_duty[c] = 0; s_div[c] = 0; m_pend[c] = 0;
            end
            e_pwm = '0;
            e_ps  = 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                lv = m_level(c);
                e_pwm[c] = en && (m_mode[c] != 0) && ((lv > m_cnt) || (lv == 63));
            end
            e_ps = en && (m_cnt == 0);
            acc  = cfg_valid && !m_pend[cfg_chan];
            if (en && m_cnt == 63) begin
                for (int c = 0; c < CH; c++) begin
                    if (m_mode[c] == 2) m_bc[c]++;
                    if (m_pend[c]) begin
                        if (s_mode[c] == 2 && m_mode[c] != 2) m_bc[c] = 0;
                        m_mode[c] = s_mode[c]; m_duty[c] = s_duty[c]; m_div[c] = s_div[c];
                        m_pend[c] = 0;
                    end
                end
            end
            if (acc) begin
                s_mode[cfg_chan] = cfg_mode;
                s_duty[cfg_chan] = cfg_duty;
                s_div[cfg_chan]  = cfg_step_div;
                m_pend[cfg_chan] = 1;
            end
            if (en) m_cnt = (m_cnt + 1) % 64;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input int md, input int du, input int dv);
        int t;
        cfg_chan = 2'(ch); cfg_mode = 2'(md); cfg_duty = 6'(du); cfg_step_div = 10'(dv);
        cfg_valid = 1'b1;
        t = 0;
        #1;
        while (cfg_ready !== 1'b1 && t < 200) begin
            cyc(); #1; t++;
        end
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_ready_timeout ch%0d: cfg_ready=%b, required 1", ch, cfg_ready);
        end
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic sync_ps();
        int t;
        t = 0;
        cyc();
        while (period_start !== 1'b1 && t < 200) begin
            cyc(); t++;
        end
        n_cmp++;
        if (period_start !== 1'b1) begin
            n_bad++;
            $display("FAIL period_start_timeout: period_start=%b, required 1", period_start);
        end
    endtask

    // Collects 64 samples starting at the current one (counter index 0).
    task automatic measure();
        for (int c = 0; c < CH; c++) hi[c] = 0;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) cyc();
            for (int c = 0; c < CH; c++) if (pwm_out[c] === 1'b1) hi[c]++;
            b0[k] = pwm_out[0];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cfg_valid = 1'b1;
        cfg_chan = 2'd0; cfg_mode = 2'd1; cfg_duty = 6'd20; cfg_step_div = '0;
        cyc(); cyc();
        n_cmp++;
        if (pwm_out !== 4'b0 || period_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: pwm_out=%b period_start=%b, required 0000/0", pwm_out, period_start);
        end
        rst = 1'b0; cfg_valid = 1'b0;
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: cfg_ready=%b, required 1", cfg_ready);
        end
        cyc();
        n_cmp++;
        if (period_start !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_period: period_start=%b, required 1", period_start);
        end
        measure();
        n_cmp++;
        if (hi[0] + hi[1] + hi[2] + hi[3] != 0) begin
            n_bad++;
            $display("FAIL reset_write_dropped: high cycles=%0d, required 0", hi[0] + hi[1] + hi[2] + hi[3]);
        end
    endtask

    task automatic test_static();
        sync_ps(); wr(0, 1, 16, 0); sync_ps();
        measure();
        n_cmp++;
        if (hi[0] != 16) begin
            n_bad++; $display("FAIL static16_count: high=%0d, required 16", hi[0]);
        end
        n_cmp++;
        if (b0 !== 64'h0000_0000_0000_FFFF) begin
            n_bad++; $display("FAIL static16_shape: bits=%h, required 000000000000ffff", b0);
        end
        cyc(); measure();
        n_cmp++;
        if (hi[0] != 16) begin
            n_bad++; $display("FAIL static16_second: high=%0d, required 16", hi[0]);
        end
    endtask

    task automatic test_levels();
        sync_ps(); wr(1, 1, 63, 0); wr(2, 3, 0, 0); sync_ps();
        measure();
        n_cmp++;
        if (hi[1] != 64 || hi[2] != 64 || hi[0] != 16) begin
            n_bad++;
            $display("FAIL levels_full: ch0=%0d ch1=%0d ch2=%0d, required 16/64/64", hi[0], hi[1], hi[2]);
        end
        sync_ps(); wr(1, 1, 0, 0); sync_ps();
        measure();
        n_cmp++;
        if (hi[1] != 0 || hi[2] != 64) begin
            n_bad++;
            $display("FAIL levels_zero: ch1=%0d ch2=%0d, required 0/64", hi[1], hi[2]);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        sync_ps(); wr(0, 1, 10, 0);
        cfg_chan = 2'd0; cfg_mode = 2'd1; cfg_duty = 6'd40; cfg_step_div = '0; cfg_valid = 1'b1;
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_blocked: cfg_ready=%b, required 0", cfg_ready);
        end
        t = 0;
        while (cfg_ready !== 1'b1 && t < 200) begin
            cyc(); #1; t++;
        end
        n_cmp++;
        if (t != 62) begin
            n_bad++; $display("FAIL b2b_wait: waited %0d cycles, required 62", t);
        end
        cyc(); cfg_valid = 1'b0;
        n_cmp++;
        if (period_start !== 1'b1) begin
            n_bad++; $display("FAIL b2b_accept_at_wrap: period_start=%b, required 1", period_start);
        end
        measure();
        n_cmp++;
        if (hi[0] != 10) begin
            n_bad++; $display("FAIL b2b_first: high=%0d, required 10", hi[0]);
        end
        cyc(); measure();
        n_cmp++;
        if (hi[0] != 40) begin
            n_bad++; $display("FAIL b2b_second: high=%0d, required 40", hi[0]);
        end
    endtask

    task automatic test_breathe();
        sync_ps(); wr(3, 2, 0, 0); sync_ps();
        for (int p = 0; p < 130; p++) begin
            if (p > 0) cyc();
            measure();
            n_cmp++;
            if (hi[3] != ramp_at(p)) begin
                n_bad++; $display("FAIL breathe_div0 period %0d: high=%0d, required %0d", p, hi[3], ramp_at(p));
            end
        end
        sync_ps(); wr(3, 0, 0, 0); sync_ps(); wr(3, 2, 0, 2); sync_ps();
        for (int p = 0; p < 30; p++) begin
            if (p > 0) cyc();
            measure();
            n_cmp++;
            if (hi[3] != ramp_at(p / 3)) begin
                n_bad++; $display("FAIL breathe_div2 period %0d: high=%0d, required %0d", p, hi[3], ramp_at(p / 3));
            end
        end
    endtask

    task automatic test_rst_mid();
        sync_ps(); wr(1, 1, 20, 0);
        cfg_chan = 2'd1; #1;
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_pending_before: cfg_ready=%b, required 0", cfg_ready);
        end
        for (int i = 0; i < 28; i++) cyc();
        n_cmp++;
        if (pwm_out[0] !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_active_before: pwm_out[0]=%b, required 1", pwm_out[0]);
        end
        rst = 1'b1; cyc(); rst = 1'b0;
        #1;
        n_cmp++;
        if (pwm_out !== 4'b0 || period_start !== 1'b0 || cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_after: pwm_out=%b period_start=%b cfg_ready=%b, required 0000/0/1",
                     pwm_out, period_start, cfg_ready);
        end
        cyc();
        n_cmp++;
        if (period_start !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_counter_zero: period_start=%b, required 1", period_start);
        end
        measure();
        n_cmp++;
        if (hi[0] + hi[1] + hi[2] + hi[3] != 0) begin
            n_bad++; $display("FAIL rstmid_all_off: high cycles=%0d, required 0", hi[0] + hi[1] + hi[2] + hi[3]);
        end
    endtask

    task automatic test_en_gap();
        int bad, t, h;
        sync_ps(); wr(0, 1, 32, 0); sync_ps();
        for (int i = 0; i < 19; i++) cyc();
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (pwm_out !== 4'b0 || period_start !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL en_gap_quiet: %0d active samples, required 0", bad);
        end
        en = 1'b1;
        cyc();
        n_cmp++;
        if (pwm_out[0] !== 1'b1) begin
            n_bad++; $display("FAIL en_gap_resume: pwm_out[0]=%b, required 1", pwm_out[0]);
        end
        h = 1; t = 0;
        while (t < 200) begin
            cyc(); t++;
            if (period_start === 1'b1) break;
            if (pwm_out[0] === 1'b1) h++;
        end
        n_cmp++;
        if (t != 44 || h != 12) begin
            n_bad++; $display("FAIL en_gap_held_count: cycles=%0d high=%0d, required 44/12", t, h);
        end
    endtask

    task automatic test_random();
        int rdiv[CH];
        for (int c = 0; c < CH; c++) rdiv[c] = $urandom_range(0, 3);
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            en           = ($urandom_range(0, 19) != 0);
            rst          = ($urandom_range(0, 599) == 0);
            cfg_valid    = ($urandom_range(0, 2) == 0);
            cfg_chan     = 2'($urandom_range(0, 3));
            cfg_mode     = 2'($urandom_range(0, 3));
            cfg_duty     = 6'($urandom);
            cfg_step_div = 10'(rdiv[cfg_chan]);
            #1;
            n_cmp++;
            if (cfg_ready !== !m_pend[cfg_chan]) begin
                n_bad++; $display("FAIL rand_ready cycle %0d: cfg_ready=%b, required %b", i, cfg_ready, !m_pend[cfg_chan]);
            end
            cyc();
            n_cmp++;
            if (pwm_out !== e_pwm || period_start !== e_ps) begin
                n_bad++;
                $display("FAIL rand_outputs cycle %0d: pwm_out=%b period_start=%b, required %b/%b",
                         i, pwm_out, period_start, e_pwm, e_ps);
            end
        end
        rst = 1'b0; cfg_valid = 1'b0; en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        cfg_chan = '0; cfg_mode = '0; cfg_duty = '0; cfg_step_div = '0;
        test_reset();
        test_static();
        test_levels();
        test_back_to_back();
        test_breathe();
        test_rst_mid();
        test_en_gap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
